// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_rx
// Brief    : PS/2 keyboard receiver: glitch filter, frame checks, E0/F0 prefix
//            folding and a show-ahead output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int DEPTH      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       EN,
  input  logic       rd,
  output logic [7:0] code,
  output logic       brk,
  output logic       ext,
  output logic       valid,
  output logic       full,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [1:0]          r_ps2c_sync;
  logic [1:0]          r_ps2d_sync;
  logic                r_ps2c_filt;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                r_fall_tick;
  logic                w_ps2c_s;
  logic                w_ps2d_s;

  assign w_ps2c_s = r_ps2c_sync[1];
  assign w_ps2d_s = r_ps2d_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ps2c_sync <= 2'b11;
      r_ps2d_sync <= 2'b11;
    end else begin
      r_ps2c_sync <= {r_ps2c_sync[0], ps2c};
      r_ps2d_sync <= {r_ps2d_sync[0], ps2d};
    end
  end

  // The filtered level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ps2c_filt <= 1'b1;
      r_filt_cnt  <= '0;
      r_fall_tick <= 1'b0;
    end else begin
      r_fall_tick <= 1'b0;
      if (w_ps2c_s == r_ps2c_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
        r_filt_cnt  <= '0;
        r_ps2c_filt <= w_ps2c_s;
        r_fall_tick <= ~w_ps2c_s;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM, timeout and prefix decoder
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_pend_ext;
  logic              r_pend_brk;
  logic              r_parity_err;
  logic              r_frame_err;

  logic w_stop_tick;
  logic w_odd_ok;
  logic w_byte_ok;
  logic w_is_prefix;
  logic w_push;
  logic w_timeout;

  assign w_stop_tick = r_fall_tick && (r_state == S_STOP);
  assign w_odd_ok    = ^{r_shift, r_parity};
  assign w_byte_ok   = w_stop_tick && w_ps2d_s && w_odd_ok;
  assign w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0);
  assign w_push      = EN && w_byte_ok && !w_is_prefix;
  assign w_timeout   = (r_state != S_IDLE) && !r_fall_tick &&
                       (r_to_cnt == c_TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_pend_ext   <= 1'b0;
      r_pend_brk   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (!EN) begin
        r_state    <= S_IDLE;
        r_to_cnt   <= '0;
        r_pend_ext <= 1'b0;
        r_pend_brk <= 1'b0;
      end else begin
        if ((r_state == S_IDLE) || r_fall_tick) begin
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end

        if (w_timeout) begin
          r_state     <= S_IDLE;
          r_frame_err <= 1'b1;
          r_pend_ext  <= 1'b0;
          r_pend_brk  <= 1'b0;
        end else if (r_fall_tick) begin
          case (r_state)
            S_IDLE: begin
              if (!w_ps2d_s) begin
                r_state   <= S_DATA;
                r_bit_cnt <= 3'd0;
              end
            end
            S_DATA: begin
              r_shift   <= {w_ps2d_s, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_PARITY;
              end
            end
            S_PARITY: begin
              r_parity <= w_ps2d_s;
              r_state  <= S_STOP;
            end
            S_STOP: begin
              r_state <= S_IDLE;
              // A bad stop bit masks any parity failure.
              if (!w_ps2d_s) begin
                r_frame_err <= 1'b1;
                r_pend_ext  <= 1'b0;
                r_pend_brk  <= 1'b0;
              end else if (!w_odd_ok) begin
                r_parity_err <= 1'b1;
                r_pend_ext   <= 1'b0;
                r_pend_brk   <= 1'b0;
              end else if (r_shift == 8'hE0) begin
                r_pend_ext <= 1'b1;
              end else if (r_shift == 8'hF0) begin
                r_pend_brk <= 1'b1;
              end else begin
                r_pend_ext <= 1'b0;
                r_pend_brk <= 1'b0;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO: entry = {ext, brk, code}
  // --------------------------------------------------------------------------
  logic [9:0]          r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_CNT_W-1:0]  w_count_nxt;
  logic                r_valid;
  logic                r_full;
  logic                r_overflow;
  logic                w_pop;
  logic                w_wr;
  logic                w_drop;
  logic [9:0]          w_head;

  assign w_pop  = rd && r_valid;
  assign w_wr   = w_push && (!r_full || w_pop);
  assign w_drop = w_push && r_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {r_pend_ext, r_pend_brk, r_shift};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == c_CNT_W'(DEPTH));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_pop && r_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Memory is not reset, so the head is masked while the FIFO is empty.
  assign w_head     = r_mem[r_rd_ptr];
  assign code       = r_valid ? w_head[7:0] : 8'h00;
  assign brk        = r_valid & w_head[8];
  assign ext        = r_valid & w_head[9];
  assign valid      = r_valid;
  assign full       = r_full;
  assign overflow   = r_overflow;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire
